sequence_generator: RTL and testbench
=====================================

// Module: sequence_generator
// PURPOSE
//  Serial pattern transmitter: drives a programmable PAT_W-bit pattern MSB-first
//  onto a 1-bit stream, repeated N times with optional idle gap bits between repeats.
//  Sits upstream of sequence_detector (dout -> din) as a stimulus/loopback source
//  and as the bit source for on-chip pattern-signalling links.
// PARAMETERS
//  PAT_W  3  pattern width in bits (>=1)
//  CNT_W  8  width of repeat count and sent_count
//  GAP_W  4  width of inter-pattern gap length
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request; accepted only in IDLE
//  abort       in   1      synchronous cancel of a running transfer
//  pattern     in   PAT_W  pattern to send; bit PAT_W-1 goes first
//  reps        in   CNT_W  number of pattern repeats
//  gap         in   GAP_W  idle cycles between repeats (0 = back-to-back)
//  dout        out  1      serial data; 0 when dout_valid=0
//  dout_valid  out  1      dout carries a pattern bit this cycle
//  busy        out  1      transfer in progress (SHIFT or GAP)
//  done        out  1      1-cycle pulse on normal completion
//  sent_count  out  CNT_W  completed patterns in current/last transfer
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, dout=0, dout_valid=0, busy=0, done=0,
//    sent_count=0, internal pattern/rep/gap/bit counters=0.
//  - States: IDLE, SHIFT, GAP, DONE.
//  - IDLE: at an edge with start=1, latch pattern/reps/gap, clear sent_count.
//    reps=0 -> DONE. reps>0 -> SHIFT; first bit pattern[PAT_W-1] on dout with
//    dout_valid=1 right after that same edge (no extra latency).
//  - SHIFT: one bit per cycle, MSB first, PAT_W cycles. On the edge ending the last
//    bit: sent_count+1 (saturates at 2^CNT_W-1), remaining reps-1.
//    Reps remaining and gap=0 -> SHIFT, next pattern's MSB in the following cycle.
//    Reps remaining and gap>0 -> GAP.
//    No reps remaining -> DONE.
//  - GAP: exactly gap cycles, dout=0, dout_valid=0, busy=1; then SHIFT.
//  - DONE: one cycle, done=1, busy=0, dout_valid=0; then IDLE. start ignored in DONE.
//  - Transfer length, reps>0: reps*PAT_W + (reps-1)*gap busy cycles.
//  - start while busy/DONE: ignored; latched values do not change.
//    pattern/reps/gap changes mid-transfer: no effect.
//  - abort=1 in SHIFT or GAP: IDLE at the next edge. dout=0, dout_valid=0, busy=0,
//    no done pulse, sent_count holds. abort has priority over start in the same cycle.
//    abort in IDLE/DONE: no effect.
//  - rst mid-transfer: immediate return to reset values; no done pulse.
//  - sent_count holds its value in IDLE until the next accepted start.
// TESTING
//  1. pattern=3'b101, reps=3, gap=0, start 1 cycle -> dout 101101101 with dout_valid
//     high 9 consecutive cycles; done 1 cycle after the last bit; sent_count=3;
//     looped into sequence_detector its count reaches 3.
//  2. pattern=3'b110, reps=2, gap=2 -> dout/valid 1,1,0 / 0,0 (valid=0) / 1,1,0;
//     busy high 8 cycles; sent_count=2.
//  3. reps=0, start -> done pulses the cycle after acceptance; dout_valid never high;
//     sent_count=0.
//  4. reps=4, gap=0; abort during the 2nd bit of the 2nd repeat -> IDLE next edge,
//     no done, sent_count=1; new start afterwards runs normally and clears sent_count.
//  5. start pulsed again while busy with a different pattern -> ignored; output
//     stream unchanged.
//  6. rst asserted asynchronously mid-SHIFT (between edges) -> outputs go to reset
//     values immediately; after release, start re-runs the full transfer.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB-first, repeated
// reps times with gap idle cycles between repeats. All outputs are registered.
//
// state | meaning
// IDLE  | waiting for start; sent_count holds the last result
// SHIFT | driving pattern bits, one per cycle
// GAP   | idle bits between two repeats
// DONE  | one-cycle completion pulse
module sequence_generator #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count
);

    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] SENT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [PAT_W-1:0]   pat_q, pat_n;
    logic [PAT_W-1:0]   sh_q, sh_n;
    logic [PAT_W-1:0]   shifted;
    logic [CNT_W-1:0]   reps_q, reps_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
    logic               dout_n, valid_n, busy_n, done_n;
    logic [CNT_W-1:0]   sent_n;

    assign shifted = sh_q << 1;

    // State, latched configuration, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pat_q      <= '0;
            sh_q       <= '0;
            reps_q     <= '0;
            gap_q      <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_count <= '0;
        end else begin
            state      <= state_n;
            pat_q      <= pat_n;
            sh_q       <= sh_n;
            reps_q     <= reps_n;
            gap_q      <= gap_n;
            gap_cnt    <= gap_cnt_n;
            bit_cnt    <= bit_cnt_n;
            dout       <= dout_n;
            dout_valid <= valid_n;
            busy       <= busy_n;
            done       <= done_n;
            sent_count <= sent_n;
        end
    end

    // Next state plus the output values for the cycle after the coming edge.
    always_comb begin
        state_n   = state;
        pat_n     = pat_q;
        sh_n      = sh_q;
        reps_n    = reps_q;
        gap_n     = gap_q;
        gap_cnt_n = gap_cnt;
        bit_cnt_n = bit_cnt;
        dout_n    = 1'b0;
        valid_n   = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        sent_n    = sent_count;

        case (state)
            IDLE: begin
                if (start) begin
                    pat_n  = pattern;
                    reps_n = reps;
                    gap_n  = gap;
                    sent_n = '0;
                    if (reps == '0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n   = SHIFT;
                        sh_n      = pattern;
                        bit_cnt_n = BIT_LAST;
                        dout_n    = pattern[PAT_W-1];
                        valid_n   = 1'b1;
                        busy_n    = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (bit_cnt != '0) begin
                    sh_n      = shifted;
                    bit_cnt_n = bit_cnt - 1'b1;
                    dout_n    = shifted[PAT_W-1];
                    valid_n   = 1'b1;
                    busy_n    = 1'b1;
                end else begin
                    // Last bit of a repeat ends at this edge.
                    sent_n = (sent_count == SENT_MAX) ? sent_count : sent_count + 1'b1;
                    reps_n = reps_q - 1'b1;
                    if (reps_q > CNT_W'(1)) begin
                        if (gap_q == '0) begin
                            sh_n      = pat_q;
                            bit_cnt_n = BIT_LAST;
                            dout_n    = pat_q[PAT_W-1];
                            valid_n   = 1'b1;
                        end else begin
                            state_n   = GAP;
                            gap_cnt_n = gap_q;
                        end
                        busy_n = 1'b1;
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end

            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (gap_cnt == GAP_W'(1)) begin
                    state_n   = SHIFT;
                    sh_n      = pat_q;
                    bit_cnt_n = BIT_LAST;
                    dout_n    = pat_q[PAT_W-1];
                    valid_n   = 1'b1;
                    busy_n    = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt - 1'b1;
                    busy_n    = 1'b1;
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: directed scenarios plus random transfers,
// compared cycle by cycle against a stream model built from the transfer rules.
module tb_sequence_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] pattern = '0;
    logic [7:0] reps = '0;
    logic [3:0] gap = '0;
    logic       dout, dout_valid, busy, done;
    logic [7:0] sent_count;

    int n_checks = 0;
    int n_errors = 0;

    sequence_generator #(.PAT_W(3), .CNT_W(8), .GAP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .reps       (reps),
        .gap        (gap),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {done, busy, dout_valid, dout, sent_count}
    function automatic logic [31:0] obs_vec();
        return {20'd0, done, busy, dout_valid, dout, sent_count};
    endfunction

    function automatic logic [31:0] mk(input bit d, input bit b, input bit v,
                                       input bit o, input int s);
        return {20'd0, d, b, v, o, 8'(s)};
    endfunction

    // Sends one transfer and checks every cycle from acceptance to idle.
    // abort_at >= 0 raises abort during that cycle index; noise scrambles
    // the configuration inputs and pulses start while the transfer runs.
    task automatic run_xfer(input logic [2:0] p, input logic [7:0] r, input logic [3:0] g,
                            input int abort_at, input bit noise);
        logic [31:0] exp_q[$];
        int          fin;
        bit          aborted;
        for (int k = 0; k < int'(r); k++) begin
            for (int b = 2; b >= 0; b--)
                exp_q.push_back(mk(0, 1, 1, p[b], k));
            if (k < int'(r) - 1)
                for (int j = 0; j < int'(g); j++)
                    exp_q.push_back(mk(0, 1, 0, 0, k + 1));
        end
        fin = (int'(r) > 255) ? 255 : int'(r);
        exp_q.push_back(mk(1, 0, 0, 0, fin));

        @(negedge clk);
        pattern = p; reps = r; gap = g; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        aborted = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            check("stream", obs_vec(), exp_q[i]);
            if (noise) begin
                pattern = 3'($urandom);
                reps    = 8'($urandom_range(0, 6));
                gap     = 4'($urandom_range(0, 4));
                start   = 1'($urandom);
            end
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                start = 1'b0;
                fin = int'(exp_q[i][7:0]);
                check("abort", obs_vec(), mk(0, 0, 0, 0, fin));
                aborted = 1'b1;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("idle", obs_vec(), mk(0, 0, 0, 0, fin));
        if (!aborted) begin
            // abort in IDLE must do nothing
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("idle_abort", obs_vec(), mk(0, 0, 0, 0, fin));
        end
    endtask

    initial begin
        #2;
        check("reset", obs_vec(), mk(0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        check("reset_rel", obs_vec(), mk(0, 0, 0, 0, 0));

        run_xfer(3'b101, 8'd3, 4'd0, -1, 1'b0);
        run_xfer(3'b110, 8'd2, 4'd2, -1, 1'b0);
        run_xfer(3'b111, 8'd0, 4'd3, -1, 1'b0);
        run_xfer(3'b011, 8'd4, 4'd0, 4, 1'b0);
        run_xfer(3'b100, 8'd2, 4'd1, -1, 1'b0);
        run_xfer(3'b001, 8'd3, 4'd2, 4, 1'b0);
        run_xfer(3'b010, 8'd3, 4'd1, -1, 1'b1);
        run_xfer(3'b110, 8'd1, 4'd5, -1, 1'b0);

        // asynchronous reset between edges mid-SHIFT
        @(negedge clk);
        pattern = 3'b101; reps = 8'd3; gap = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst", obs_vec(), mk(0, 1, 1, 0, 0));
        #2 rst = 1'b1;
        #1 check("async_rst", obs_vec(), mk(0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        check("rst_hold", obs_vec(), mk(0, 0, 0, 0, 0));
        run_xfer(3'b101, 8'd3, 4'd1, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [2:0] p;
            logic [7:0] r;
            logic [3:0] g;
            int         len, ab;
            p = 3'($urandom);
            r = 8'($urandom_range(0, 5));
            g = 4'($urandom_range(0, 3));
            len = int'(r) * 3 + ((r > 0) ? (int'(r) - 1) * int'(g) : 0);
            ab = -1;
            if (len > 0 && $urandom_range(0, 3) == 0)
                ab = $urandom_range(0, len - 1);
            run_xfer(p, r, g, ab, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
